// File: rtl/blink_gen_pkg.sv
// Shared encodings for the blink generator: config modes, channel states, burst constants.
package blink_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_BURST   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_TOGGLE,
    CH_ONESHOT,
    CH_BURST
  } chan_state_e;

  localparam int unsigned BURST_PULSES = 3;
  // High and low phases alternate, starting and ending high.
  localparam int unsigned BURST_PHASES = 2 * BURST_PULSES - 1;
  localparam int unsigned PHASE_W      = $clog2(BURST_PHASES + 1);

  function automatic chan_state_e mode_to_state(input mode_e mode);
    case (mode)
      MODE_TOGGLE:  return CH_TOGGLE;
      MODE_ONESHOT: return CH_ONESHOT;
      MODE_BURST:   return CH_BURST;
      default:      return CH_OFF;
    endcase
  endfunction

endpackage

// File: rtl/blink_chan.sv
// One blink channel: half-period counter, mode FSM and registered blink/tick outputs.
// Tick edge-detect logic exists only when BLINK_GEN_TICK_EN is defined.
module blink_chan
  import blink_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = 27,
  parameter int unsigned RST_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  mode_e            load_mode,
  input  logic [CNT_W-1:0] load_div,
  output logic             blink,
  output logic             tick
);

  chan_state_e        state_q;
  chan_state_e        state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   div_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;
  logic               blink_d;
  logic               wrap;
  logic               last_phase;

  assign wrap       = (cnt_q == div_q - CNT_W'(1));
  assign last_phase = (phase_q == PHASE_W'(BURST_PHASES - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= CH_TOGGLE;
      cnt_q   <= '0;
      div_q   <= CNT_W'(RST_DIV);
      phase_q <= '0;
      blink   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      blink   <= blink_d;
      if (load) begin
        div_q <= load_div;
      end
    end
  end

  // Next state: a load always wins; finite patterns fall back to OFF
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = mode_to_state(load_mode);
    end else begin
      case (state_q)
        CH_ONESHOT: if (wrap) state_d = CH_OFF;
        CH_BURST:   if (wrap && last_phase) state_d = CH_OFF;
        default:    ;
      endcase
    end
  end

  // Counter, burst phase and next blink level
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    blink_d = blink;
    if (load) begin
      cnt_d   = '0;
      phase_d = '0;
      blink_d = (load_mode == MODE_ONESHOT) || (load_mode == MODE_BURST);
    end else if (state_q != CH_OFF) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) begin
        case (state_q)
          CH_TOGGLE:  blink_d = ~blink;
          CH_ONESHOT: blink_d = 1'b0;
          CH_BURST: begin
            blink_d = ~blink;
            phase_d = last_phase ? '0 : phase_q + PHASE_W'(1);
          end
          default:    ;
        endcase
      end
    end
  end

`ifdef BLINK_GEN_TICK_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      tick <= 1'b0;
    end else begin
      tick <= blink_d ^ blink;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/blink_gen.sv
// Multi-channel blink generator: config handshake and channel decode around N_CH blink_chan
// instances. Define BLINK_GEN_TICK_EN to enable the per-channel o_tick edge strobes.
module blink_gen
  import blink_gen_pkg::*;
#(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned CNT_W   = 27,
  parameter  int unsigned RST_DIV = 50_000_000,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic [N_CH-1:0]  o_blink,
  output logic [N_CH-1:0]  o_tick
);

  logic             accept;
  logic [CNT_W-1:0] div_eff;

  assign accept  = i_cfg_valid & o_cfg_ready;
  assign div_eff = (i_cfg_div == '0) ? CNT_W'(1) : i_cfg_div;

  // Ready drops for exactly the cycle following an accept
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_cfg_ready <= 1'b0;
    end else begin
      o_cfg_ready <= ~accept;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    blink_chan #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_chan (
      .clk       (i_clk),
      .clr       (i_clr),
      .load      (accept && (i_cfg_ch == CH_W'(g))),
      .load_mode (mode_e'(i_cfg_mode)),
      .load_div  (div_eff),
      .blink     (o_blink[g]),
      .tick      (o_tick[g])
    );
  end

endmodule

// File: tb/tb_blink_gen.sv
// Scoreboard bench for blink_gen: a closed-form per-channel waveform model pushes expected
// {ready, tick, blink} each cycle; test tasks pop and compare after every clock edge.
module tb_blink_gen;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RST_DIV = 5;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned VW      = 2 * N_CH + 1;

  logic             i_clk;
  logic             i_clr;
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [CH_W-1:0]  i_cfg_ch;
  logic [1:0]       i_cfg_mode;
  logic [CNT_W-1:0] i_cfg_div;
  logic [N_CH-1:0]  o_blink;
  logic [N_CH-1:0]  o_tick;

  blink_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .RST_DIV(RST_DIV)) dut (
    .i_clk       (i_clk),
    .i_clr       (i_clr),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_mode  (i_cfg_mode),
    .i_cfg_div   (i_cfg_div),
    .o_blink     (o_blink),
    .o_tick      (o_tick)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks   = 0;
  int failures = 0;

  // Model: mode, half-period and cycles elapsed since the channel was (re)loaded
  int              m_mode [N_CH];
  int              m_div  [N_CH];
  int              m_t    [N_CH];
  logic [N_CH-1:0] m_prev = '0;
  logic            m_rdy  = 1'b0;
  logic [VW-1:0]   sb [$];
  logic [VW-1:0]   got;
  logic [VW-1:0]   exp_v;

  function automatic logic exp_blink(input int mode, input int div, input int t);
    case (mode)
      1:       return ((t / div) % 2) == 1;
      2:       return t < div;
      3:       return (t < 5 * div) && ((t / div) % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Predict the outputs after the coming edge, queue them, then take the edge
  task automatic advance();
    logic [N_CH-1:0] b;
    logic [N_CH-1:0] tk;
    logic            acc;
    acc = i_cfg_valid && m_rdy && !i_clr;
    for (int i = 0; i < N_CH; i++) begin
      if (i_clr) begin
        m_mode[i] = 1;
        m_div[i]  = RST_DIV;
        m_t[i]    = 0;
      end else if (acc && int'(i_cfg_ch) == i) begin
        m_mode[i] = int'(i_cfg_mode);
        m_div[i]  = (i_cfg_div == '0) ? 1 : int'(i_cfg_div);
        m_t[i]    = 0;
      end else begin
        m_t[i] = m_t[i] + 1;
      end
      b[i]  = exp_blink(m_mode[i], m_div[i], m_t[i]);
      tk[i] = i_clr ? 1'b0 : (b[i] != m_prev[i]);
    end
`ifndef BLINK_GEN_TICK_EN
    tk = '0;
`endif
    m_prev = b;
    m_rdy  = !i_clr && !acc;
    sb.push_back({m_rdy, tk, b});
    @(posedge i_clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int mode, input int div);
    i_cfg_valid = 1'b1;
    i_cfg_ch    = CH_W'(ch);
    i_cfg_mode  = 2'(mode);
    i_cfg_div   = CNT_W'(div);
  endtask

  task automatic test_reset();
    int rise_k;
    i_clr  = 1'b1;
    rise_k = -1;
    for (int k = 0; k < 3; k++) begin
      advance();
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL reset_hold k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
    end
    i_clr = 1'b0;
    for (int k = 0; k < 22; k++) begin
      advance();
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL reset_release k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
      if (rise_k < 0 && o_blink === '1) rise_k = k;
    end
    checks++;
    if (rise_k !== 4) begin $display("FAIL reset_first_rise got=%0d exp=4", rise_k); failures++; end
  endtask

  task automatic test_toggle();
    cfg(1, 1, 3);
    for (int k = 0; k < 14; k++) begin
      advance();
      i_cfg_valid = 1'b0;
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL toggle_ch1 k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
    end
  endtask

  task automatic test_oneshot();
    int ticks;
    int highs;
    ticks = 0;
    highs = 0;
    cfg(2, 0, 4);
    for (int k = 0; k < 14; k++) begin
      advance();
      i_cfg_valid = 1'b0;
      if (k == 1) cfg(2, 2, 4);
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL oneshot_ch2 k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
      if (k >= 2) begin
        ticks += int'(o_tick[2]);
        highs += int'(o_blink[2]);
      end
    end
    checks++;
    if (highs !== 4) begin $display("FAIL oneshot_high_len got=%0d exp=4", highs); failures++; end
    checks++;
`ifdef BLINK_GEN_TICK_EN
    if (ticks !== 2) begin $display("FAIL oneshot_ticks got=%0d exp=2", ticks); failures++; end
`else
    if (ticks !== 0) begin $display("FAIL oneshot_ticks got=%0d exp=0", ticks); failures++; end
`endif
  endtask

  task automatic test_burst();
    int          ticks;
    logic [11:0] pat;
    ticks = 0;
    pat   = '0;
    cfg(3, 0, 2);
    for (int k = 0; k < 18; k++) begin
      advance();
      i_cfg_valid = 1'b0;
      if (k == 1) cfg(3, 3, 2);
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL burst_ch3 k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
      if (k >= 2) ticks += int'(o_tick[3]);
      if (k >= 2 && k < 14) pat = {pat[10:0], o_blink[3]};
    end
    checks++;
    if (pat !== 12'b110011001100) begin $display("FAIL burst_pattern got=%b exp=110011001100", pat); failures++; end
    checks++;
`ifdef BLINK_GEN_TICK_EN
    if (ticks !== 6) begin $display("FAIL burst_ticks got=%0d exp=6", ticks); failures++; end
`else
    if (ticks !== 0) begin $display("FAIL burst_ticks got=%0d exp=0", ticks); failures++; end
`endif
  endtask

  task automatic test_div_zero();
    cfg(0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      advance();
      i_cfg_valid = 1'b0;
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL div_zero_ch0 k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
    end
  endtask

  task automatic test_back_to_back();
    cfg(0, 1, 2);
    for (int k = 0; k < 16; k++) begin
      advance();
      if (k == 0) cfg(1, 2, 3);
      else if (k == 1) cfg(2, 3, 1);
      else i_cfg_valid = 1'b0;
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
    end
  endtask

  task automatic test_abort();
    int late_ticks;
    late_ticks = 0;
    cfg(2, 2, 4);
    for (int k = 0; k < 12; k++) begin
      advance();
      i_cfg_valid = 1'b0;
      if (k == 1) cfg(2, 0, 4);
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL abort_oneshot k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
      if (k >= 3) late_ticks += int'(o_tick[2]);
    end
    checks++;
    if (late_ticks !== 0) begin $display("FAIL abort_residual_tick got=%0d exp=0", late_ticks); failures++; end
  endtask

  task automatic test_clr_mid_burst();
    cfg(3, 3, 2);
    for (int k = 0; k < 20; k++) begin
      advance();
      i_cfg_valid = 1'b0;
      if (k == 2) i_clr = 1'b1;
      if (k == 4) i_clr = 1'b0;
      got = {o_cfg_ready, o_tick, o_blink}; exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin $display("FAIL clr_mid_burst k=%0d got=%b exp=%b", k, got, exp_v); failures++; end
    end
  endtask

  initial begin
    i_clr       = 1'b1;
    i_cfg_valid = 1'b0;
    i_cfg_ch    = '0;
    i_cfg_mode  = '0;
    i_cfg_div   = '0;
    test_reset();
    test_toggle();
    test_oneshot();
    test_burst();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_clr_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
